// File: rtl/hack_rom_loader_if.sv
// Host ioctl download bus plus the ROM write port and CPU control outputs of the loader.
interface hack_rom_loader_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic                  ioctl_download;
  logic                  ioctl_wr;
  logic [24:0]           ioctl_addr;
  logic [7:0]            ioctl_dout;
  logic [7:0]            ioctl_index;
  logic                  ioctl_wait;
  logic                  rom_we;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  overflow;
  logic [15:0]           word_count;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait, rom_we, rom_addr, rom_data, cpu_reset, load_done,
           overflow, word_count
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait, rom_we, rom_addr, rom_data, cpu_reset, load_done,
           overflow, word_count
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Assembles big-endian ioctl byte pairs into 16-bit ROM writes and holds the
// CPU in reset for the download plus a fixed settle period.
module hack_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'h00,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  hack_rom_loader_if.slave  bus
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sel_q;
  logic                  pend_q, pend_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]           rom_data_q, rom_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           word_count_q, word_count_d;

  logic                  sel, sel_rise, start;
  logic                  addr_ovf, odd;
  logic [ADDR_WIDTH-1:0] waddr;

  assign sel      = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign sel_rise = sel && !sel_q;
  assign waddr    = bus.ioctl_addr[ADDR_WIDTH:1];
  assign addr_ovf = |bus.ioctl_addr[24:ADDR_WIDTH+1];
  assign odd      = bus.ioctl_addr[0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    hi_d         = hi_q;
    paddr_d      = paddr_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    load_done_d  = 1'b0;
    overflow_d   = overflow_q;
    start        = 1'b0;
    word_count_d = (rom_we_q && (word_count_q != '1)) ? word_count_q + 16'd1
                                                      : word_count_q;

    case (state_q)
      IDLE: begin
        if (sel_rise) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end

      LOAD: begin
        if (!sel) begin
          state_d = pend_q ? FLUSH : HOLD;
          cnt_d   = CW'(HOLD_CYCLES);
        end else if (bus.ioctl_wr) begin
          if (addr_ovf) begin
            overflow_d = 1'b1;
          end else if (!odd) begin
            // A second high byte pushes out the previous one with a zero low byte.
            if (pend_q) begin
              rom_we_d   = 1'b1;
              rom_addr_d = paddr_q;
              rom_data_d = {hi_q, 8'h00};
            end
            hi_d    = bus.ioctl_dout;
            paddr_d = waddr;
            pend_d  = 1'b1;
          end else begin
            rom_we_d   = 1'b1;
            rom_addr_d = waddr;
            rom_data_d = (pend_q && (paddr_q == waddr)) ? {hi_q, bus.ioctl_dout}
                                                        : {8'h00, bus.ioctl_dout};
            pend_d     = 1'b0;
          end
        end
      end

      FLUSH: begin
        rom_we_d   = 1'b1;
        rom_addr_d = paddr_q;
        rom_data_d = {hi_q, 8'h00};
        pend_d     = 1'b0;
        state_d    = HOLD;
        cnt_d      = CW'(HOLD_CYCLES);
      end

      HOLD: begin
        if (sel_rise) begin
          state_d = LOAD;
          start   = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          state_d     = IDLE;
          load_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = HOLD;
    endcase

    if (start) begin
      word_count_d = '0;
      overflow_d   = 1'b0;
      pend_d       = 1'b0;
    end

    cpu_reset_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HOLD;
      cnt_q        <= CW'(HOLD_CYCLES);
      sel_q        <= 1'b0;
      pend_q       <= 1'b0;
      hi_q         <= '0;
      paddr_q      <= '0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel;
      pend_q       <= pend_d;
      hi_q         <= hi_d;
      paddr_q      <= paddr_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  // Stall the host for the cycle a write is presented so writes never collide.
  assign bus.ioctl_wait = rom_we_q;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.cpu_reset  = cpu_reset_q | reset;
  assign bus.load_done  = load_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed scenarios for the ROM loader with hand-computed expected writes and timing.
module tb_hack_rom_loader;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   we_total = 0;

  always #5 clk = ~clk;

  hack_rom_loader_if #(.ADDR_WIDTH(15)) bus ();

  hack_rom_loader #(
    .ROM_INDEX   (8'h00),
    .ADDR_WIDTH  (15),
    .HOLD_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.rom_we === 1'b1) we_total++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.load_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.ioctl_index = 8'h00;
    tick(); tick(); tick();
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b want 1", bus.cpu_reset); end
    checks++; if ({bus.rom_we, bus.ioctl_wait, bus.load_done, bus.overflow} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b want 0000", {bus.rom_we, bus.ioctl_wait, bus.load_done, bus.overflow}); end
    checks++; if ({bus.rom_addr, bus.rom_data, bus.word_count} !== 47'd0) begin
      errors++; $display("FAIL rst_regs: got %h want 0", {bus.rom_addr, bus.rom_data, bus.word_count}); end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if ({bus.cpu_reset, bus.load_done} !== 2'b10) begin
        errors++; $display("FAIL rst_hold[%0d]: got %b want 10", i, {bus.cpu_reset, bus.load_done}); end
      tick();
    end
    checks++; if ({bus.cpu_reset, bus.load_done} !== 2'b01) begin
      errors++; $display("FAIL rst_done: got %b want 01", {bus.cpu_reset, bus.load_done}); end
    tick();
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_done_pulse: got %b want 0", bus.load_done); end
  endtask

  task automatic test_basic;
    int we0;
    we0 = we_total;
    bus.ioctl_index = 8'h00;
    bus.ioctl_download = 1'b1;
    tick();
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_cpu_reset: got %b want 1", bus.cpu_reset); end
    send_byte(25'd0, 8'h12);
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL basic_hi_nowrite: got %b want 0", bus.rom_we); end
    send_byte(25'd1, 8'h34);
    checks++; if ({bus.rom_we, bus.ioctl_wait, bus.rom_addr, bus.rom_data} !== {1'b1, 1'b1, 15'd0, 16'h1234}) begin
      errors++; $display("FAIL basic_w0: got %h want %h", {bus.rom_we, bus.ioctl_wait, bus.rom_addr, bus.rom_data}, {1'b1, 1'b1, 15'd0, 16'h1234}); end
    tick();
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL basic_we_pulse: got %b want 0", bus.rom_we); end
    send_byte(25'd2, 8'hAB);
    send_byte(25'd3, 8'hCD);
    checks++; if ({bus.rom_we, bus.ioctl_wait, bus.rom_addr, bus.rom_data} !== {1'b1, 1'b1, 15'd1, 16'hABCD}) begin
      errors++; $display("FAIL basic_w1: got %h want %h", {bus.rom_we, bus.ioctl_wait, bus.rom_addr, bus.rom_data}, {1'b1, 1'b1, 15'd1, 16'hABCD}); end
    tick();
    bus.ioctl_download = 1'b0;
    tick();
    checks++; if (bus.word_count !== 16'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", bus.word_count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if ({bus.cpu_reset, bus.load_done} !== 2'b10) begin
        errors++; $display("FAIL basic_hold[%0d]: got %b want 10", i, {bus.cpu_reset, bus.load_done}); end
      tick();
    end
    checks++; if ({bus.cpu_reset, bus.load_done} !== 2'b01) begin
      errors++; $display("FAIL basic_done: got %b want 01", {bus.cpu_reset, bus.load_done}); end
    checks++; if (we_total - we0 !== 2) begin errors++; $display("FAIL basic_we_count: got %0d want 2", we_total - we0); end
  endtask

  task automatic test_odd_length;
    int we0;
    bit seen;
    we0 = we_total;
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(25'd0, 8'h01);
    send_byte(25'd1, 8'h02);
    checks++; if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== {1'b1, 15'd0, 16'h0102}) begin
      errors++; $display("FAIL odd_w0: got %h want %h", {bus.rom_we, bus.rom_addr, bus.rom_data}, {1'b1, 15'd0, 16'h0102}); end
    tick();
    send_byte(25'd2, 8'h03);
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL odd_hi_nowrite: got %b want 0", bus.rom_we); end
    bus.ioctl_download = 1'b0;
    tick();
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL odd_flush_early: got %b want 0", bus.rom_we); end
    tick();
    checks++; if ({bus.rom_we, bus.ioctl_wait, bus.rom_addr, bus.rom_data} !== {1'b1, 1'b1, 15'd1, 16'h0300}) begin
      errors++; $display("FAIL odd_flush: got %h want %h", {bus.rom_we, bus.ioctl_wait, bus.rom_addr, bus.rom_data}, {1'b1, 1'b1, 15'd1, 16'h0300}); end
    tick();
    checks++; if (bus.word_count !== 16'd2) begin errors++; $display("FAIL odd_count: got %0d want 2", bus.word_count); end
    wait_done(40, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL odd_done: got %b want 1", seen); end
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL odd_cpu_release: got %b want 0", bus.cpu_reset); end
    checks++; if (we_total - we0 !== 2) begin errors++; $display("FAIL odd_we_count: got %0d want 2", we_total - we0); end
  endtask

  task automatic test_back_to_back;
    bit seen;
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(25'd4, 8'h11);
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL b2b_hi_nowrite: got %b want 0", bus.rom_we); end
    send_byte(25'd6, 8'h22);
    checks++; if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== {1'b1, 15'd2, 16'h1100}) begin
      errors++; $display("FAIL b2b_push: got %h want %h", {bus.rom_we, bus.rom_addr, bus.rom_data}, {1'b1, 15'd2, 16'h1100}); end
    tick();
    send_byte(25'd7, 8'h33);
    checks++; if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== {1'b1, 15'd3, 16'h2233}) begin
      errors++; $display("FAIL b2b_pair: got %h want %h", {bus.rom_we, bus.rom_addr, bus.rom_data}, {1'b1, 15'd3, 16'h2233}); end
    tick();
    send_byte(25'd9, 8'h44);
    checks++; if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== {1'b1, 15'd4, 16'h0044}) begin
      errors++; $display("FAIL b2b_lone_lo: got %h want %h", {bus.rom_we, bus.rom_addr, bus.rom_data}, {1'b1, 15'd4, 16'h0044}); end
    tick();
    bus.ioctl_download = 1'b0;
    tick();
    checks++; if (bus.word_count !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", bus.word_count); end
    wait_done(40, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", seen); end
  endtask

  task automatic test_overflow;
    int we0;
    bit seen;
    we0 = we_total;
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(25'h10000, 8'h55);
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL ovf_nowrite: got %b want 0", bus.rom_we); end
    tick();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
    bus.ioctl_download = 1'b0;
    wait_done(40, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b want 1", seen); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    checks++; if (we_total - we0 !== 0) begin errors++; $display("FAIL ovf_we_count: got %0d want 0", we_total - we0); end
    bus.ioctl_download = 1'b1;
    tick();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    bus.ioctl_download = 1'b0;
    wait_done(40, seen);
  endtask

  task automatic test_index;
    int we0;
    we0 = we_total;
    bus.ioctl_index = 8'h01;
    bus.ioctl_download = 1'b1;
    tick();
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL idx_cpu_reset_start: got %b want 0", bus.cpu_reset); end
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    tick(); tick();
    checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL idx_cpu_reset: got %b want 0", bus.cpu_reset); end
    checks++; if (we_total - we0 !== 0) begin errors++; $display("FAIL idx_we_count: got %0d want 0", we_total - we0); end
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid;
    int we0;
    bit seen;
    we0 = we_total;
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(25'd0, 8'h99);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if ({bus.cpu_reset, bus.load_done} !== 2'b10) begin
        errors++; $display("FAIL mid_hold[%0d]: got %b want 10", i, {bus.cpu_reset, bus.load_done}); end
      tick();
    end
    checks++; if ({bus.cpu_reset, bus.load_done} !== 2'b01) begin
      errors++; $display("FAIL mid_done: got %b want 01", {bus.cpu_reset, bus.load_done}); end
    checks++; if (we_total - we0 !== 0) begin errors++; $display("FAIL mid_we_count: got %0d want 0", we_total - we0); end
    checks++; if (bus.word_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus.word_count); end
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(25'd1, 8'h42);
    checks++; if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== {1'b1, 15'd0, 16'h0042}) begin
      errors++; $display("FAIL mid_discard: got %h want %h", {bus.rom_we, bus.rom_addr, bus.rom_data}, {1'b1, 15'd0, 16'h0042}); end
    tick();
    bus.ioctl_download = 1'b0;
    wait_done(40, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_final_done: got %b want 1", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_back_to_back();
    test_overflow();
    test_index();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Sequences host-side ROM downloads (byte stream on the ioctl bus) into the Hack computer's 16-bit instruction ROM.
- Assembles big-endian byte pairs into words and issues single-cycle ROM write strobes.
- Holds the CPU in reset for the whole download plus a fixed settle period.
- Sits between the ioctl bus and the ROM write port / CPU reset of the Computer block.

Parameters:
- ROM_INDEX, 8'h00, ioctl_index value that selects the instruction ROM; all other indices are ignored.
- ADDR_WIDTH, 15, ROM word-address width (32K words).
- HOLD_CYCLES, 16, number of cycles cpu_reset stays high after the download ends (minimum 1).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte strobe, one cycle per byte.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download target index.
- ioctl_wait  out  1  asks the host to stall the next strobe.
- rom_we  out  1  ROM write enable, one-cycle pulse.
- rom_addr  out  ADDR_WIDTH  ROM word address.
- rom_data  out  16  ROM write data.
- cpu_reset  out  1  reset to CPU/Computer.
- load_done  out  1  one-cycle pulse when the post-load hold ends.
- overflow  out  1  sticky flag: a byte addressed beyond ROM capacity was received.
- word_count  out  16  words written by the last or current download.

Behaviour:
- Reset values:
  - rom_we, ioctl_wait, load_done, overflow = 0; rom_addr, rom_data, word_count = 0; cpu_reset = 1.
  - FSM enters HOLD with its counter preloaded, so cpu_reset stays high for HOLD_CYCLES cycles after reset deasserts, then load_done pulses.
- Selected download: sel = ioctl_download && ioctl_index == ROM_INDEX. A byte is accepted when sel && ioctl_wr.
- States: IDLE, LOAD, FLUSH, HOLD.
  - IDLE → LOAD when sel rises. On entry: word_count and overflow clear; pending flag clears.
  - LOAD → FLUSH when sel falls and a high byte is pending.
  - LOAD → HOLD when sel falls and nothing is pending.
  - FLUSH: emits the pending word with low byte 8'h00 (one cycle), then → HOLD.
  - HOLD: counts HOLD_CYCLES, then → IDLE and pulses load_done in the last HOLD cycle.
  - If sel rises again while in HOLD → LOAD, with no load_done.
- cpu_reset = 1 in every state except IDLE, and while reset is high.
- Byte assembly:
  - Even byte address = high byte; odd byte address = low byte. Word address = ioctl_addr[ADDR_WIDTH:1].
  - Even byte: store it in the hi register with its word address and set pending.
    - If a word is already pending, that word is first emitted as {hi, 8'h00} in the same strobe.
  - Odd byte:
    - If pending with a matching word address, emit {hi, byte}.
    - Otherwise emit {8'h00, byte} to that address.
    - Pending clears in either case.
- Write timing:
  - rom_addr, rom_data and rom_we are registered; rom_we is high in the cycle after the accepting strobe (latency 1).
  - ioctl_wait is high in the same cycle as rom_we.
  - word_count increments (saturating at 16'hFFFF) on every rom_we.
- Overflow: a byte with ioctl_addr[24:ADDR_WIDTH+1] != 0 is dropped (no write, no pending change) and sets overflow. overflow stays set until the next download start or reset.
- Strobes while not in LOAD, or with a non-matching index: ignored.
- Reset mid-download:
  - All registers return to reset values and the FSM enters HOLD.
  - Any pending byte is discarded.
  - Strobes during HOLD are ignored unless sel rises again.
- At most one rom_we per cycle. The host honours ioctl_wait, so two writes never collide.

Test Plan:
- Reset: assert reset 3 cycles, release → cpu_reset = 1 for 16 cycles, then load_done pulses for 1 cycle and cpu_reset = 0.
- Download index 0, bytes 0x12,0x34,0xAB,0xCD at addr 0..3 → rom_we pulses with (addr 0, 0x1234) and (addr 1, 0xABCD), each one cycle after its odd strobe. Also: word_count = 2; cpu_reset high from download start through 16 cycles after the end.
- Odd-length download of 3 bytes 0x01,0x02,0x03 → writes 0x0102 @0, then FLUSH writes 0x0300 @1 after ioctl_download falls; word_count = 2.
- Byte at ioctl_addr 0x10000 during download → no rom_we, overflow = 1; overflow clears at the next download start.
- Download with ioctl_index = 1 → no rom_we and cpu_reset stays 0.
- Reset asserted after the first high byte → no write of that byte; cpu_reset held and load_done pulses 16 cycles after reset releases.
